// File: rtl/mux2to1_data_memory_if.sv
// Write-back selector bus: the two candidate words, MemtoReg select, and the
// combinational/shadow outputs. master drives the inputs, slave is the selector.
interface mux2to1_data_memory_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] input0;
    logic [WIDTH-1:0] input1;
    logic             select;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic [CNT_W-1:0] toggle_cnt;

    // No handshake: every signal is level-valid; out is live in the same
    // cycle and the shadow outputs are valid one clock edge after sampling.
    modport master (
        output input0, input1, select,
        input  out, out_q, sel_q, toggle_cnt
    );

    modport slave (
        input  input0, input1, select,
        output out, out_q, sel_q, toggle_cnt
    );
endinterface

// File: rtl/mux2to1_data_memory.sv
// Write-back source selector (ALU result vs. memory word) with a debug shadow stage.
// Define MUX2TO1_DM_REGOUT_EN to make out_q a real register instead of a copy of out.
module mux2to1_data_memory #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    mux2to1_data_memory_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] out_w;
    logic             sel_q_r;
    logic [CNT_W-1:0] cnt_r;

    // Zero-latency select path; ternary keeps agreeing bits on an unknown select.
    assign out_w   = bus.select ? bus.input1 : bus.input0;
    assign bus.out = out_w;

    // Only sampled select values are compared, so glitches between edges are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sel_q_r <= bus.select;
            if ((bus.select != sel_q_r) && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign bus.sel_q      = sel_q_r;
    assign bus.toggle_cnt = cnt_r;

`ifdef MUX2TO1_DM_REGOUT_EN
    logic [WIDTH-1:0] out_q_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_r <= '0;
        end else begin
            out_q_r <= out_w;
        end
    end

    assign bus.out_q = out_q_r;
`else
    assign bus.out_q = out_w;
`endif
endmodule

// File: tb/tb_mux2to1_data_memory.sv
// Directed bench for mux2to1_data_memory: combinational select, shadow stage,
// asynchronous reset and counter saturation on a CNT_W=2 instance.
module tb_mux2to1_data_memory;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux2to1_data_memory_if #(.WIDTH(32), .CNT_W(16)) bus ();
    mux2to1_data_memory_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

    mux2to1_data_memory #(.WIDTH(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux2to1_data_memory #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Clock / reset block: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_out_q_rst(input logic [31:0] out_now);
`ifdef MUX2TO1_DM_REGOUT_EN
        return 32'h0;
`else
        return out_now;
`endif
    endfunction

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.input0  = '0;
        bus.input1  = '0;
        bus.select  = 1'b0;
        bus2.input0 = '0;
        bus2.input1 = '0;
        bus2.select = 1'b0;
        #2;
        check("rst_sel_q", 64'(bus.sel_q), 64'h0);
        check("rst_cnt", 64'(bus.toggle_cnt), 64'h0);
        check("rst_out_q", 64'(bus.out_q), 64'(exp_out_q_rst(32'h0)));

        // Combinational patterns while held in reset: out must still be live.
        bus.input0 = 32'h12345678; bus.input1 = 32'h87654321; bus.select = 1'b0;
        #1 check("sel0_basic", 64'(bus.out), 64'h12345678);
        bus.select = 1'b1;
        #1 check("sel1_basic", 64'(bus.out), 64'h87654321);
        check("rst_out_q_live", 64'(bus.out_q), 64'(exp_out_q_rst(32'h87654321)));

        bus.input0 = 32'h0; bus.input1 = 32'hAAAAAAAA; bus.select = 1'b0;
        #1 check("zero_in0", 64'(bus.out), 64'h0);
        bus.input0 = 32'hBBBBBBBB; bus.input1 = 32'h0; bus.select = 1'b1;
        #1 check("zero_in1", 64'(bus.out), 64'h0);

        bus.input0 = 32'hFFFFFFFF; bus.select = 1'b0;
        #1 check("ones_in0", 64'(bus.out), 64'hFFFFFFFF);
        bus.input1 = 32'hFFFFFFFF; bus.input0 = 32'h22222222; bus.select = 1'b1;
        #1 check("ones_in1", 64'(bus.out), 64'hFFFFFFFF);
        check("rst_hold_cnt", 64'(bus.toggle_cnt), 64'h0);

        // Release on a falling edge; toggle select every 5 units, offset from the edges.
        bus.input0 = 32'h12345678; bus.input1 = 32'h87654321; bus.select = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2 bus.select = 1'b1;
            #1 check("glitch_out1", 64'(bus.out), 64'h87654321);
            #4 bus.select = 1'b0;
            #1 check("glitch_out0", 64'(bus.out), 64'h12345678);
            #2;
        end
        // select was 1 at every sampled edge: one toggle only (0 -> 1 at the first edge).
        check("glitch_cnt", 64'(bus.toggle_cnt), 64'h1);
        check("glitch_sel_q", 64'(bus.sel_q), 64'h1);

        bus.select = 1'b0; tick();
        check("toggle_cnt2", 64'(bus.toggle_cnt), 64'h2);
        check("toggle_sel_q0", 64'(bus.sel_q), 64'h0);
        bus.select = 1'b1; tick();
        check("toggle_cnt3", 64'(bus.toggle_cnt), 64'h3);
        check("out_q_pre_rst", 64'(bus.out_q), 64'h87654321);
        bus.select = 1'b1; tick();
        check("steady_cnt3", 64'(bus.toggle_cnt), 64'h3);

        // Mid-cycle asynchronous reset.
        #2 rst = 1'b1;
        #1;
        check("async_out_q", 64'(bus.out_q), 64'(exp_out_q_rst(32'h87654321)));
        check("async_sel_q", 64'(bus.sel_q), 64'h0);
        check("async_cnt", 64'(bus.toggle_cnt), 64'h0);
        check("async_out", 64'(bus.out), 64'h87654321);
        tick();
        check("rst_hold_edge_cnt", 64'(bus.toggle_cnt), 64'h0);
        rst = 1'b0;
        tick();
        check("post_rst_cnt", 64'(bus.toggle_cnt), 64'h1);
        check("post_rst_sel_q", 64'(bus.sel_q), 64'h1);
        check("post_rst_out_q", 64'(bus.out_q), 64'h87654321);

        // Saturation on the 2-bit counter instance.
        bus2.input0 = 32'h0000_00A5; bus2.input1 = 32'h0000_005A;
        check("sat_start", 64'(bus2.toggle_cnt), 64'h0);
        bus2.select = 1'b1; tick();
        bus2.select = 1'b0; tick();
        bus2.select = 1'b1; tick();
        check("sat_reach3", 64'(bus2.toggle_cnt), 64'h3);
        bus2.select = 1'b0; tick();
        bus2.select = 1'b1; tick();
        check("sat_hold3", 64'(bus2.toggle_cnt), 64'h3);
        check("sat_sel_q", 64'(bus2.sel_q), 64'h1);
        check("sat_out", 64'(bus2.out), 64'h0000005A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
